// File: rtl/ucsbece154a_ctrl_pkg.sv
// Shared encodings for the wait-state multicycle controller and datapath.
// State codes, opcodes, ALU codes and the per-state control word decode.
package ucsbece154a_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_LUI      = 4'd11,
      S_JALRADR  = 4'd12,
      S_TRAP     = 4'd13,
      S_RESET    = 4'd14
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   typedef enum logic [1:0] {
      ALUOP_ADD = 2'b00,
      ALUOP_SUB = 2'b01,
      ALUOP_FN  = 2'b10
   } aluop_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef struct packed {
      logic       pc_upd;
      logic       branch;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       adr;
      logic [1:0] res;
      aluop_t     alu_op;
      logic       mem_req;
      logic       illegal;
   } ctrl_t;

   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.pc_upd   = 1'b1;
            c.ir_write = 1'b1;
            c.src_b    = 2'b10;
            c.res      = 2'b10;
            c.mem_req  = 1'b1;
         end
         S_DECODE: begin
            c.src_a = 2'b01;
            c.src_b = 2'b01;
         end
         S_MEMADR, S_JALRADR: begin
            c.src_a = 2'b10;
            c.src_b = 2'b01;
         end
         S_MEMREAD: begin
            c.adr     = 1'b1;
            c.mem_req = 1'b1;
         end
         S_MEMWB: begin
            c.reg_write = 1'b1;
            c.res       = 2'b01;
         end
         S_MEMWRITE: begin
            c.mem_write = 1'b1;
            c.adr       = 1'b1;
            c.mem_req   = 1'b1;
         end
         S_EXECR: begin
            c.src_a  = 2'b10;
            c.alu_op = ALUOP_FN;
         end
         S_EXECI: begin
            c.src_a  = 2'b10;
            c.src_b  = 2'b01;
            c.alu_op = ALUOP_FN;
         end
         S_ALUWB: c.reg_write = 1'b1;
         S_JAL: begin
            c.pc_upd = 1'b1;
            c.src_a  = 2'b01;
            c.src_b  = 2'b10;
         end
         S_BRANCH: begin
            c.branch = 1'b1;
            c.src_a  = 2'b10;
            c.alu_op = ALUOP_SUB;
         end
         S_LUI: c.src_b = 2'b01;
         // TRAP keeps only the sticky flag; no enable may fire
         S_TRAP: c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ucsbece154a_controller_ws_if.sv
// Controller <-> datapath bundle: IR fields and flags in, enables and selects out.
interface ucsbece154a_controller_ws_if;
   logic [6:0] op_i;
   logic [2:0] funct3_i;
   logic       funct7_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       PCWrite_o;
   logic       MemWrite_o;
   logic       IRWrite_o;
   logic       RegWrite_o;
   logic       AdrSrc_o;
   logic [1:0] ALUSrcA_o;
   logic [1:0] ALUSrcB_o;
   logic [1:0] ResultSrc_o;
   logic [3:0] ALUControl_o;
   logic [2:0] ImmSrc_o;
   logic       mem_req_o;
   logic       illegal_o;

   modport master (
      input  op_i, funct3_i, funct7_i, zero_i, mem_ready_i,
      output PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, AdrSrc_o,
      output ALUSrcA_o, ALUSrcB_o, ResultSrc_o, ALUControl_o, ImmSrc_o,
      output mem_req_o, illegal_o
   );

   modport slave (
      output op_i, funct3_i, funct7_i, zero_i, mem_ready_i,
      input  PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, AdrSrc_o,
      input  ALUSrcA_o, ALUSrcB_o, ResultSrc_o, ALUControl_o, ImmSrc_o,
      input  mem_req_o, illegal_o
   );
endinterface

// File: rtl/ucsbece154a_alu_decoder.sv
// ALUOp/funct3/funct7 -> ALU control code.
// Also flags funct3 values this build cannot execute.
module ucsbece154a_alu_decoder
   import ucsbece154a_ctrl_pkg::*;
#(
   parameter bit ALU_EXT = 1'b0
) (
   input  aluop_t     alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       op5,
   output logic [3:0] alu_control,
   output logic       unsupported
);

   always_comb begin
      unsupported = 1'b0;
      case (funct3)
         F3_ADD, F3_SLT, F3_OR, F3_AND: unsupported = 1'b0;
         default: unsupported = !ALU_EXT;
      endcase
   end

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FN: begin
            case (funct3)
               // only R-type (op5) uses bit 30 to pick sub
               F3_ADD: alu_control = (funct7 & op5) ? ALU_SUB : ALU_ADD;
               F3_SLT: alu_control = ALU_SLT;
               F3_OR:  alu_control = ALU_OR;
               F3_AND: alu_control = ALU_AND;
               F3_XOR: if (ALU_EXT) alu_control = ALU_XOR;
               F3_SLL: if (ALU_EXT) alu_control = ALU_SLL;
               F3_SRL: if (ALU_EXT) alu_control = ALU_SRL;
               F3_SLTU: if (ALU_EXT) alu_control = ALU_SLTU;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/ucsbece154a_controller_ws.sv
// Multicycle RV32I control FSM with memory wait states and an illegal trap.
// Control word is registered from state_next so it is valid with its state.
module ucsbece154a_controller_ws
   import ucsbece154a_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter bit ALU_EXT     = 1'b0
) (
   input logic clk,
   input logic reset,
   ucsbece154a_controller_ws_if.master bus
);

   state_t     state, state_next;
   ctrl_t      ctrl_q;
   logic       ready;
   logic       in_fetch;
   logic       f3_bad;
   logic       br_ok;
   logic       br_take;
   logic [3:0] alu_control;

   assign ready    = bus.mem_ready_i | ~MEM_WAIT_EN;
   assign in_fetch = (state == S_FETCH);
   assign br_ok    = (bus.funct3_i == F3_BEQ) |
                     (bus.funct3_i == F3_BNE);
   assign br_take  = bus.zero_i ^ bus.funct3_i[0];

   ucsbece154a_alu_decoder #(
      .ALU_EXT(ALU_EXT)
   ) u_alu_dec (
      .alu_op     (ctrl_q.alu_op),
      .funct3     (bus.funct3_i),
      .funct7     (bus.funct7_i),
      .op5        (bus.op_i[5]),
      .alu_control(alu_control),
      .unsupported(f3_bad)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_RESET;
         ctrl_q <= '0;
      end else begin
         state  <= state_next;
         ctrl_q <= ctrl_of(state_next);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_RESET: state_next = S_FETCH;
         S_FETCH: if (ready) state_next = S_DECODE;
         S_DECODE: begin
            case (bus.op_i)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:    state_next = f3_bad ? S_TRAP : S_EXECR;
               OP_I:    state_next = f3_bad ? S_TRAP : S_EXECI;
               OP_BR:   state_next = br_ok ? S_BRANCH : S_TRAP;
               OP_JAL:  state_next = S_JAL;
               OP_JALR: state_next = S_JALRADR;
               OP_LUI:  state_next = S_LUI;
               default: state_next = S_TRAP;
            endcase
         end
         S_MEMADR:
            state_next = (bus.op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (ready) state_next = S_MEMWB;
         S_MEMWRITE: if (ready) state_next = S_FETCH;
         S_MEMWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
         S_EXECR, S_EXECI, S_JAL, S_LUI: state_next = S_ALUWB;
         S_JALRADR: state_next = S_JAL;
         S_TRAP:    state_next = S_TRAP;
         default:   state_next = S_TRAP;
      endcase
   end

   always_comb begin
      bus.ImmSrc_o = IMM_I;
      case (bus.op_i)
         OP_SW:   bus.ImmSrc_o = IMM_S;
         OP_BR:   bus.ImmSrc_o = IMM_B;
         OP_JAL:  bus.ImmSrc_o = IMM_J;
         OP_LUI:  bus.ImmSrc_o = IMM_U;
         default: bus.ImmSrc_o = IMM_I;
      endcase
   end

   // PC/IR strobe only on the cycle the fetch actually completes
   assign bus.PCWrite_o    = (ctrl_q.pc_upd & (ready | ~in_fetch)) |
                             (ctrl_q.branch & br_take);
   assign bus.IRWrite_o    = ctrl_q.ir_write & ready;
   assign bus.MemWrite_o   = ctrl_q.mem_write;
   assign bus.RegWrite_o   = ctrl_q.reg_write;
   assign bus.AdrSrc_o     = ctrl_q.adr;
   assign bus.ALUSrcA_o    = ctrl_q.src_a;
   assign bus.ALUSrcB_o    = ctrl_q.src_b;
   assign bus.ResultSrc_o  = ctrl_q.res;
   assign bus.ALUControl_o = alu_control;
   assign bus.mem_req_o    = ctrl_q.mem_req;
   assign bus.illegal_o    = ctrl_q.illegal;

endmodule

// File: tb/tb_ucsbece154a_controller_ws.sv
// Scoreboard bench: directed sequences queue expected control words,
// a negedge monitor pops and compares them against the selected DUT.
module tb_ucsbece154a_controller_ws;

   // {PCW,MW,IRW,RW,Adr}_SrcA_SrcB_Res_ALUCtl_{req,ill}
   localparam logic [16:0] W_ZERO  = 17'b00000_00_00_00_0000_00;
   localparam logic [16:0] W_IF_R  = 17'b10100_00_10_10_0000_10;
   localparam logic [16:0] W_IF_W  = 17'b00000_00_10_10_0000_10;
   localparam logic [16:0] W_DEC   = 17'b00000_01_01_00_0000_00;
   localparam logic [16:0] W_ADR   = 17'b00000_10_01_00_0000_00;
   localparam logic [16:0] W_MWR   = 17'b01001_00_00_00_0000_10;
   localparam logic [16:0] W_BR_T  = 17'b10000_10_00_00_0001_00;
   localparam logic [16:0] W_BR_N  = 17'b00000_10_00_00_0001_00;
   localparam logic [16:0] W_JAL   = 17'b10000_01_10_00_0000_00;
   localparam logic [16:0] W_WB    = 17'b00010_00_00_00_0000_00;
   localparam logic [16:0] W_TRAP  = 17'b00000_00_00_00_0000_01;
   localparam logic [16:0] W_XR    = 17'b00000_10_00_00_0100_00;
   localparam logic [16:0] W_SUBR  = 17'b00000_10_00_00_0001_00;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] f3;
   logic       f7;
   logic       zero;
   logic       rdy;

   logic [20:0] exp_q[$];
   string       name_q[$];
   int          checks;
   int          failures;

   ucsbece154a_controller_ws_if ifa();
   ucsbece154a_controller_ws_if ifb();

   assign ifa.op_i        = op;
   assign ifa.funct3_i    = f3;
   assign ifa.funct7_i    = f7;
   assign ifa.zero_i      = zero;
   assign ifa.mem_ready_i = rdy;
   assign ifb.op_i        = op;
   assign ifb.funct3_i    = f3;
   assign ifb.funct7_i    = f7;
   assign ifb.zero_i      = zero;
   assign ifb.mem_ready_i = rdy;

   ucsbece154a_controller_ws #(
      .MEM_WAIT_EN(1'b1),
      .ALU_EXT    (1'b0)
   ) dut_a (
      .clk  (clk),
      .reset(reset),
      .bus  (ifa)
   );

   ucsbece154a_controller_ws #(
      .MEM_WAIT_EN(1'b0),
      .ALU_EXT    (1'b1)
   ) dut_b (
      .clk  (clk),
      .reset(reset),
      .bus  (ifb)
   );

   logic [19:0] obs_a, obs_b;
   assign obs_a = {ifa.ImmSrc_o, ifa.PCWrite_o, ifa.MemWrite_o,
                   ifa.IRWrite_o, ifa.RegWrite_o, ifa.AdrSrc_o,
                   ifa.ALUSrcA_o, ifa.ALUSrcB_o, ifa.ResultSrc_o,
                   ifa.ALUControl_o, ifa.mem_req_o, ifa.illegal_o};
   assign obs_b = {ifb.ImmSrc_o, ifb.PCWrite_o, ifb.MemWrite_o,
                   ifb.IRWrite_o, ifb.RegWrite_o, ifb.AdrSrc_o,
                   ifb.ALUSrcA_o, ifb.ALUSrcB_o, ifb.ResultSrc_o,
                   ifb.ALUControl_o, ifb.mem_req_o, ifb.illegal_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: one queued expectation per cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [20:0] e;
         logic [19:0] act;
         string       nm;
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = e[20] ? obs_b : obs_a;
         checks++;
         if (act !== e[19:0]) begin
            failures++;
            $display("FAIL %s dut_%s got=%b expected=%b",
                     nm, e[20] ? "b" : "a", act, e[19:0]);
         end
      end
   end

   task automatic chk(input bit sel, input logic [2:0] imm,
                      input logic [16:0] w, input string nm);
      exp_q.push_back({sel, imm, w});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_dec(input logic [2:0] imm, input string nm);
      chk(0, imm, W_IF_R, {nm, "_if"});
      chk(0, imm, W_DEC, {nm, "_dec"});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      op       = 7'b0100011;
      f3       = 3'b010;
      f7       = 1'b0;
      zero     = 1'b0;
      rdy      = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk(0, 3'b001, W_ZERO, "reset_hold");
      reset = 1'b1;
      chk(0, 3'b001, W_ZERO, "reset_rel");
      // sw with two data wait states
      fetch_dec(3'b001, "sw");
      chk(0, 3'b001, W_ADR, "sw_adr");
      rdy = 1'b0;
      chk(0, 3'b001, W_MWR, "sw_wait0");
      chk(0, 3'b001, W_MWR, "sw_wait1");
      rdy = 1'b1;
      chk(0, 3'b001, W_MWR, "sw_ready");
      // fetch with three wait states, then bne taken
      op   = 7'b1100011;
      f3   = 3'b001;
      zero = 1'b0;
      rdy  = 1'b0;
      for (int i = 0; i < 3; i++) chk(0, 3'b010, W_IF_W, "if_wait");
      rdy = 1'b1;
      chk(0, 3'b010, W_IF_R, "if_ready");
      chk(0, 3'b010, W_DEC, "bne_dec");
      chk(0, 3'b010, W_BR_T, "bne_taken");
      zero = 1'b1;
      fetch_dec(3'b010, "bne2");
      chk(0, 3'b010, W_BR_N, "bne_not_taken");
      f3 = 3'b000;
      fetch_dec(3'b010, "beq");
      chk(0, 3'b010, W_BR_T, "beq_taken");
      // jalr
      op   = 7'b1100111;
      zero = 1'b0;
      fetch_dec(3'b000, "jalr");
      chk(0, 3'b000, W_ADR, "jalr_adr");
      chk(0, 3'b000, W_JAL, "jalr_jal");
      chk(0, 3'b000, W_WB, "jalr_wb");
      // R-type sub
      op = 7'b0110011;
      f7 = 1'b1;
      fetch_dec(3'b000, "sub");
      chk(0, 3'b000, W_SUBR, "sub_exec");
      chk(0, 3'b000, W_WB, "sub_wb");
      // xor without extension traps
      f3 = 3'b100;
      f7 = 1'b0;
      fetch_dec(3'b000, "xor_a");
      chk(0, 3'b000, W_TRAP, "xor_trap0");
      chk(0, 3'b000, W_TRAP, "xor_trap1");
      reset = 1'b0;
      chk(0, 3'b000, W_ZERO, "trap_reset");
      // xor on the extended, no-wait build; ready held low
      reset = 1'b1;
      rdy   = 1'b0;
      chk(1, 3'b000, W_ZERO, "b_reset_rel");
      chk(1, 3'b000, W_IF_R, "b_fetch_nowait");
      chk(1, 3'b000, W_DEC, "b_dec");
      chk(1, 3'b000, W_XR, "b_xor_exec");
      chk(1, 3'b000, W_WB, "b_xor_wb");
      chk(1, 3'b000, W_IF_R, "b_refetch");
      reset = 1'b0;
      chk(1, 3'b000, W_ZERO, "b_reset");
      // opcode 0 traps; flag sticky for 10 cycles
      reset = 1'b1;
      rdy   = 1'b1;
      op    = 7'b0000000;
      f3    = 3'b001;
      chk(0, 3'b000, W_ZERO, "op0_reset_rel");
      fetch_dec(3'b000, "op0");
      for (int i = 0; i < 10; i++) begin
         rdy  = i[0];
         zero = i[1];
         chk(0, 3'b000, W_TRAP, "op0_trap");
      end
      reset = 1'b0;
      chk(0, 3'b000, W_ZERO, "illegal_clear");
      // reset during a fetch wait aborts at once
      reset = 1'b1;
      rdy   = 1'b0;
      op    = 7'b0000011;
      f3    = 3'b010;
      chk(0, 3'b000, W_ZERO, "abort_rel");
      chk(0, 3'b000, W_IF_W, "abort_wait0");
      chk(0, 3'b000, W_IF_W, "abort_wait1");
      reset = 1'b0;
      chk(0, 3'b000, W_ZERO, "abort_reset");
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
